// File: rtl/branch_unit.sv
// Registered branch-resolution unit with an optional 2-bit-counter BHT.
// Define BRANCH_UNIT_BHT_EN to build the BHT; otherwise fetch sees static not-taken.
module branch_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_LSB   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_taken,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            branch,
    input  logic            jump,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            cnd,
    output logic            mispredict,
    output logic            illegal,
    output logic [31:0]     mp_count
);

    logic        r_out_valid;
    logic        r_cnd;
    logic        r_mispredict;
    logic        r_illegal;
    logic [31:0] r_mp_count;

    logic w_accept;
    logic w_cnd;
    logic w_illegal;
    logic w_legal_br;
    logic w_mispredict;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A jump wins over branch, so funct3 is ignored (and never illegal) for jumps.
    always_comb begin
        w_cnd     = 1'b0;
        w_illegal = 1'b0;
        if (jump) begin
            w_cnd = 1'b1;
        end else if (branch) begin
            case (funct3[2:1])
                2'b00:   w_cnd = (rs1 == rs2) ^ funct3[0];
                2'b10:   w_cnd = ($signed(rs1) < $signed(rs2)) ^ funct3[0];
                2'b11:   w_cnd = (rs1 < rs2) ^ funct3[0];
                default: w_illegal = 1'b1;
            endcase
        end
    end

    assign w_legal_br   = branch && !jump && !w_illegal;
    assign w_mispredict = w_legal_br && (w_cnd ^ pred_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_cnd        <= 1'b0;
            r_mispredict <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_cnd        <= w_cnd;
            r_mispredict <= w_mispredict;
            r_illegal    <= w_illegal;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mp_count <= '0;
        end else if (w_accept && w_mispredict && (r_mp_count != '1)) begin
            r_mp_count <= r_mp_count + 32'd1;
        end
    end

    assign out_valid  = r_out_valid;
    assign cnd        = r_cnd;
    assign mispredict = r_mispredict;
    assign illegal    = r_illegal;
    assign mp_count   = r_mp_count;

`ifdef BRANCH_UNIT_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       r_bht [BHT_DEPTH];
    logic [IDX_W-1:0] w_lk_idx;
    logic [IDX_W-1:0] w_tr_idx;
    logic             w_unused_bits;

    assign w_lk_idx      = lk_pc[IDX_LSB +: IDX_W];
    assign w_tr_idx      = pc[IDX_LSB +: IDX_W];
    assign w_unused_bits = ^{lk_pc, pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32'(BHT_DEPTH); i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_accept && w_legal_br) begin
            if (w_cnd && (r_bht[w_tr_idx] != 2'b11)) begin
                r_bht[w_tr_idx] <= r_bht[w_tr_idx] + 2'b01;
            end else if (!w_cnd && (r_bht[w_tr_idx] != 2'b00)) begin
                r_bht[w_tr_idx] <= r_bht[w_tr_idx] - 2'b01;
            end
        end
    end

    // Reads the registered counter, so a same-cycle update is seen next cycle.
    assign lk_taken = r_bht[w_lk_idx][1];
`else
    logic w_unused_bits;

    assign w_unused_bits = ^{lk_pc, pc, 32'(IDX_LSB), 32'(BHT_DEPTH)};
    assign lk_taken      = 1'b0;
`endif

endmodule
